// File: rtl/toy_phy_reg_free_list.sv
// Circular free list of physical register IDs feeding the rename pre-allocation buffer.
// Speculative (rd_ptr) and committed (cmt_ptr) read pointers let a flush rewind allocation.

module toy_phy_reg_free_list_lane #(
  parameter int DEPTH = 96,
  parameter int LANE  = 0,
  parameter int PTR_W = 7,
  parameter int CNT_W = 7
) (
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [CNT_W-1:0] spec_cnt,
  input  logic             rdy_pfx,
  input  logic             block,
  output logic             vld,
  output logic [PTR_W-1:0] rd_idx
);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0] sum;

  // Explicit compare/subtract wrap so DEPTH need not be a power of two.
  assign sum    = {1'b0, rd_ptr} + (PTR_W+1)'(LANE);
  assign rd_idx = (sum >= DEPTH_L) ? PTR_W'(sum - DEPTH_L) : PTR_W'(sum);
  assign vld    = (spec_cnt > CNT_W'(LANE)) & rdy_pfx & ~block;
endmodule

module toy_phy_reg_free_list #(
  parameter int CHANNEL          = 4,
  parameter int REL_CHANNEL      = 4,
  parameter int PHY_REG_NUM      = 128,
  parameter int ARCH_REG_NUM     = 32,
  parameter int DEPTH            = PHY_REG_NUM - ARCH_REG_NUM,
  parameter int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  output logic [CHANNEL-1:0]                         v_m_vld,
  input  logic [CHANNEL-1:0]                         v_m_rdy,
  output logic [CHANNEL-1:0][PHY_REG_ID_WIDTH-1:0]   v_m_pld,
  input  logic [REL_CHANNEL-1:0]                     v_rel_vld,
  input  logic [REL_CHANNEL-1:0][PHY_REG_ID_WIDTH-1:0] v_rel_pld,
  input  logic [$clog2(CHANNEL+1)-1:0]               cmt_alloc_cnt,
  input  logic                                       cancel_edge_en,
  output logic [$clog2(DEPTH+1)-1:0]                 free_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CA_W  = $clog2(CHANNEL + 1);
  localparam int RC_W  = $clog2(REL_CHANNEL + 1);
  localparam logic [PTR_W+1:0] DEPTH_S = (PTR_W+2)'(DEPTH);

  logic [PHY_REG_ID_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, cmt_ptr, wr_ptr;
  logic [CNT_W-1:0] spec_cnt, cmt_cnt;

  logic [CHANNEL-1:0]                rdy_pfx;
  logic [CHANNEL-1:0][PTR_W-1:0]     rd_idx;
  logic [REL_CHANNEL-1:0][PTR_W-1:0] rel_idx;
  logic [CA_W-1:0]  pop;
  logic [RC_W-1:0]  rel;
  logic [PTR_W-1:0] rd_ptr_nxt, cmt_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] spec_cnt_nxt, cmt_cnt_nxt;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W:0]   b);
    logic [PTR_W+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s >= DEPTH_S) s = s - DEPTH_S;
    return PTR_W'(s);
  endfunction

  // Ready prefix keeps handshakes an in-order contiguous run from channel 0.
  always_comb begin
    rdy_pfx    = '0;
    rdy_pfx[0] = 1'b1;
    for (int i = 1; i < CHANNEL; i++) rdy_pfx[i] = rdy_pfx[i-1] & v_m_rdy[i-1];
  end

  for (genvar i = 0; i < CHANNEL; i++) begin : g_lane
    toy_phy_reg_free_list_lane #(
      .DEPTH (DEPTH),
      .LANE  (i),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .rd_ptr   (rd_ptr),
      .spec_cnt (spec_cnt),
      .rdy_pfx  (rdy_pfx[i]),
      .block    (cancel_edge_en | rst),
      .vld      (v_m_vld[i]),
      .rd_idx   (rd_idx[i])
    );
    assign v_m_pld[i] = mem[rd_idx[i]];
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNEL; i++) pop = pop + CA_W'(v_m_vld[i] & v_m_rdy[i]);
  end

  // k-th asserted release lane lands at wr_ptr+k, packing releases densely.
  always_comb begin
    rel     = '0;
    rel_idx = '0;
    for (int j = 0; j < REL_CHANNEL; j++) begin
      rel_idx[j] = wrap_add(wr_ptr, (PTR_W+1)'(rel));
      rel        = rel + RC_W'(v_rel_vld[j]);
    end
  end

  always_comb begin
    cmt_ptr_nxt = wrap_add(cmt_ptr, (PTR_W+1)'(cmt_alloc_cnt));
    wr_ptr_nxt  = wrap_add(wr_ptr, (PTR_W+1)'(rel));
    cmt_cnt_nxt = cmt_cnt - CNT_W'(cmt_alloc_cnt) + CNT_W'(rel);
    if (cancel_edge_en) begin
      rd_ptr_nxt   = cmt_ptr_nxt;
      spec_cnt_nxt = cmt_cnt_nxt;
    end else begin
      rd_ptr_nxt   = wrap_add(rd_ptr, (PTR_W+1)'(pop));
      spec_cnt_nxt = spec_cnt - CNT_W'(pop) + CNT_W'(rel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      cmt_ptr  <= '0;
      wr_ptr   <= '0;
      spec_cnt <= CNT_W'(DEPTH);
      cmt_cnt  <= CNT_W'(DEPTH);
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      cmt_ptr  <= cmt_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      spec_cnt <= spec_cnt_nxt;
      cmt_cnt  <= cmt_cnt_nxt;
    end
  end

  // Releases are written even when the list is empty or being cancelled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= PHY_REG_ID_WIDTH'(ARCH_REG_NUM + k);
    end else begin
      for (int j = 0; j < REL_CHANNEL; j++)
        if (v_rel_vld[j]) mem[rel_idx[j]] <= v_rel_pld[j];
    end
  end

  assign free_cnt = spec_cnt;
endmodule
